// File: rtl/sm83_int_dispatch.sv
// ---------------------------------------------------------------------------
// sm83_int_dispatch
//
// Interrupt master controller and dispatch sequencer for the SM83 core.
// Owns IME, the EI one-instruction delay and HALT/wake. Pending sources
// (IE & IF) are arbitrated by fixed priority (bit 0 highest). A dispatch
// runs for five M-cycles: two idle cycles, a two-byte push of the return
// PC through the core memory port, and a final cycle that loads the
// vector into PC, the decremented SP into SP and clears the serviced IF
// bit.
//
// Ports
//   clk, rst            core clock, synchronous active-high reset
//   mcycle_tick         one-clk pulse at the end of every M-cycle
//   instr_boundary      with mcycle_tick: next M-cycle is an opcode fetch
//   ie, if_req          IE / IF register contents
//   ei/di/reti/halt_pulse  decoded instruction strobes (one clk each)
//   pc_in, sp_in        current PC (return address) and SP
//   ime                 interrupt master enable
//   halted              core sits in HALT
//   fetch_inhibit       core must not fetch or advance PC
//   halt_bug            one-clk pulse: HALT with IME=0 and an IRQ pending
//   bus_wr/bus_addr/bus_wdata  stack push request for the current M-cycle
//   pc_wr/pc_out, sp_wr/sp_out register file load strobes and values
//   if_clr              one-hot, one clk: IF bit serviced by this dispatch
// ---------------------------------------------------------------------------
module sm83_int_dispatch #(
    parameter int unsigned NUM_IRQ    = 5,
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter int unsigned VEC_STRIDE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mcycle_tick,
    input  logic               instr_boundary,
    input  logic [NUM_IRQ-1:0] ie,
    input  logic [NUM_IRQ-1:0] if_req,
    input  logic               ei_pulse,
    input  logic               di_pulse,
    input  logic               reti_pulse,
    input  logic               halt_pulse,
    input  logic [15:0]        pc_in,
    input  logic [15:0]        sp_in,
    output logic               ime,
    output logic               halted,
    output logic               fetch_inhibit,
    output logic               halt_bug,
    output logic               bus_wr,
    output logic [15:0]        bus_addr,
    output logic [7:0]         bus_wdata,
    output logic               pc_wr,
    output logic [15:0]        pc_out,
    output logic               sp_wr,
    output logic [15:0]        sp_out,
    output logic [NUM_IRQ-1:0] if_clr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALTED,
        S_D_W1,
        S_D_W2,
        S_D_PUSH_HI,
        S_D_PUSH_LO,
        S_D_JUMP
    } state_t;

    state_t             state_q;
    logic               ime_q;
    logic               ei_dly_q;
    logic               halted_q;
    logic               fetch_inhibit_q;
    logic               halt_bug_q;
    logic               bus_wr_q;
    logic [15:0]        bus_addr_q;
    logic [7:0]         bus_wdata_q;
    logic               pc_wr_q;
    logic [15:0]        pc_out_q;
    logic               sp_wr_q;
    logic [15:0]        sp_out_q;
    logic [NUM_IRQ-1:0] if_clr_q;

    // Dispatch context captured at the triggering boundary / push
    logic [15:0]        pc_q;
    logic [15:0]        sp_q;
    logic [15:0]        target_q;
    logic [NUM_IRQ-1:0] clear_q;

    // Combinational helpers
    logic [NUM_IRQ-1:0] pend_d;
    logic [NUM_IRQ-1:0] sel_onehot_d;
    logic [15:0]        vec_d;
    logic               any_pend_d;
    logic               boundary_tick_d;
    logic               ime_d;
    logic               ei_dly_d;
    logic [15:0]        vec_tbl [NUM_IRQ];

    assign pend_d          = ie & if_req;
    assign any_pend_d      = |pend_d;
    assign boundary_tick_d = mcycle_tick & instr_boundary;

    // Vector table: one fixed address per source.
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_vec
        assign vec_tbl[gi] = VEC_BASE + 16'(gi * VEC_STRIDE);
    end

    // Fixed priority: the lowest-numbered pending source wins.
    always_comb begin
        logic seen;
        seen         = 1'b0;
        sel_onehot_d = '0;
        vec_d        = 16'h0000;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (pend_d[i] && !seen) begin
                sel_onehot_d[i] = 1'b1;
                vec_d           = vec_tbl[i];
                seen            = 1'b1;
            end
        end
    end

    // IME / EI-delay update applied whenever the sequencer is not
    // starting or running a dispatch. DI beats everything; the delayed
    // EI matures on the next instruction boundary; a fresh EI re-arms
    // the delay even if an older one matures in the same clk.
    always_comb begin
        ime_d    = ime_q;
        ei_dly_d = ei_dly_q;
        if (di_pulse) begin
            ime_d    = 1'b0;
            ei_dly_d = 1'b0;
        end else begin
            if (ei_dly_q && boundary_tick_d) begin
                ime_d    = 1'b1;
                ei_dly_d = 1'b0;
            end
            if (reti_pulse) begin
                ime_d = 1'b1;
            end
            if (ei_pulse) begin
                ei_dly_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            ime_q           <= 1'b0;
            ei_dly_q        <= 1'b0;
            halted_q        <= 1'b0;
            fetch_inhibit_q <= 1'b0;
            halt_bug_q      <= 1'b0;
            bus_wr_q        <= 1'b0;
            bus_addr_q      <= 16'h0000;
            bus_wdata_q     <= 8'h00;
            pc_wr_q         <= 1'b0;
            pc_out_q        <= 16'h0000;
            sp_wr_q         <= 1'b0;
            sp_out_q        <= 16'h0000;
            if_clr_q        <= '0;
            pc_q            <= 16'h0000;
            sp_q            <= 16'h0000;
            target_q        <= 16'h0000;
            clear_q         <= '0;
        end else begin
            // Single-clk strobes default low
            halt_bug_q <= 1'b0;
            pc_wr_q    <= 1'b0;
            sp_wr_q    <= 1'b0;
            if_clr_q   <= '0;

            case (state_q)
                S_IDLE: begin
                    // A boundary where the EI delay matures never dispatches,
                    // so the instruction after EI always runs.
                    if (boundary_tick_d && ime_q && !ei_dly_q && any_pend_d) begin
                        pc_q            <= pc_in;
                        sp_q            <= sp_in;
                        ime_q           <= 1'b0;
                        fetch_inhibit_q <= 1'b1;
                        state_q         <= S_D_W1;
                    end else begin
                        ime_q    <= ime_d;
                        ei_dly_q <= ei_dly_d;
                        if (halt_pulse) begin
                            if (!ime_q && any_pend_d) begin
                                halt_bug_q <= 1'b1;
                            end else begin
                                halted_q        <= 1'b1;
                                fetch_inhibit_q <= 1'b1;
                                state_q         <= S_HALTED;
                            end
                        end
                    end
                end

                S_HALTED: begin
                    // Any M-cycle tick with a pending source wakes the core;
                    // with IME set the wake goes straight into a dispatch.
                    if (mcycle_tick && any_pend_d && ime_q) begin
                        pc_q     <= pc_in;
                        sp_q     <= sp_in;
                        ime_q    <= 1'b0;
                        halted_q <= 1'b0;
                        state_q  <= S_D_W1;
                    end else begin
                        ime_q    <= ime_d;
                        ei_dly_q <= ei_dly_d;
                        if (mcycle_tick && any_pend_d) begin
                            halted_q        <= 1'b0;
                            fetch_inhibit_q <= 1'b0;
                            state_q         <= S_IDLE;
                        end
                    end
                end

                S_D_W1: begin
                    if (mcycle_tick) begin
                        state_q <= S_D_W2;
                    end
                end

                S_D_W2: begin
                    if (mcycle_tick) begin
                        bus_wr_q    <= 1'b1;
                        bus_addr_q  <= sp_q - 16'd1;
                        bus_wdata_q <= pc_q[15:8];
                        state_q     <= S_D_PUSH_HI;
                    end
                end

                S_D_PUSH_HI: begin
                    if (mcycle_tick) begin
                        bus_addr_q  <= sp_q - 16'd2;
                        bus_wdata_q <= pc_q[7:0];
                        state_q     <= S_D_PUSH_LO;
                    end
                end

                S_D_PUSH_LO: begin
                    if (mcycle_tick) begin
                        bus_wr_q    <= 1'b0;
                        bus_addr_q  <= 16'h0000;
                        bus_wdata_q <= 8'h00;
                        // Priority is re-evaluated here: the high-byte push
                        // may have landed on IE and changed what is pending.
                        if (any_pend_d) begin
                            target_q <= vec_d;
                            clear_q  <= sel_onehot_d;
                        end else begin
                            target_q <= 16'h0000;
                            clear_q  <= '0;
                        end
                        state_q <= S_D_JUMP;
                    end
                end

                S_D_JUMP: begin
                    if (mcycle_tick) begin
                        pc_wr_q         <= 1'b1;
                        pc_out_q        <= target_q;
                        sp_wr_q         <= 1'b1;
                        sp_out_q        <= sp_q - 16'd2;
                        if_clr_q        <= clear_q;
                        fetch_inhibit_q <= 1'b0;
                        state_q         <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ime           = ime_q;
    assign halted        = halted_q;
    assign fetch_inhibit = fetch_inhibit_q;
    assign halt_bug      = halt_bug_q;
    assign bus_wr        = bus_wr_q;
    assign bus_addr      = bus_addr_q;
    assign bus_wdata     = bus_wdata_q;
    assign pc_wr         = pc_wr_q;
    assign pc_out        = pc_out_q;
    assign sp_wr         = sp_wr_q;
    assign sp_out        = sp_out_q;
    assign if_clr        = if_clr_q;

endmodule
